// File: rtl/i2c_eeprom_slave.sv
// I2C responder modelling a 256-byte 24C02-style EEPROM.
// SCL/SDA are oversampled on clk; SDA is driven open-drain via sda_oe.
module i2c_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR   = 7'b1010000,
    parameter int         PAGE_BYTES = 8
) (
    input  logic clk,
    input  logic clrn,
    input  logic scl,
    input  logic sda_in,
    output logic sda_oe,
    output logic active
);

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        WADDR,
        WADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RD_MACK,
        WAIT_STOP
    } state_t;

    localparam logic [7:0] PAGE_MASK = 8'(PAGE_BYTES - 1);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_in};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic start_evt;
    logic stop_evt;
    logic sda_bit;

    // START/STOP need SCL stable high, so an SCL edge always wins.
    assign sda_bit   = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_q;
    assign scl_fall  = ~scl_sync[1] & scl_q;
    assign start_evt = scl_sync[1] & scl_q & sda_q & ~sda_sync[1];
    assign stop_evt  = scl_sync[1] & scl_q & ~sda_q & sda_sync[1];

    state_t     state;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic [7:0] ptr;
    logic       rw;
    logic       drive;
    logic [7:0] mem [256];

    logic [7:0] rd_byte;
    logic [7:0] ptr_page_inc;
    logic       mem_we;

    assign rd_byte      = mem[ptr];
    assign ptr_page_inc = (ptr & ~PAGE_MASK) | ((ptr + 8'd1) & PAGE_MASK);
    assign mem_we       = scl_fall && (state == WDATA_ACK) && !drive;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr] <= shreg;
        end
    end

    // drive is the next SDA level; it reaches the pad one clk later.
    // In the ACK states it also marks the second half of the slot.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            bitcnt <= 3'd0;
            shreg  <= 8'd0;
            ptr    <= 8'd0;
            rw     <= 1'b0;
            drive  <= 1'b0;
            sda_oe <= 1'b0;
            active <= 1'b0;
        end else begin
            sda_oe <= drive;
            if (start_evt) begin
                state  <= DEV;
                bitcnt <= 3'd0;
                drive  <= 1'b0;
                sda_oe <= 1'b0;
                active <= 1'b0;
            end else if (stop_evt) begin
                state  <= IDLE;
                bitcnt <= 3'd0;
                drive  <= 1'b0;
                sda_oe <= 1'b0;
                active <= 1'b0;
            end else if (scl_rise) begin
                unique case (state)
                    DEV: begin
                        shreg  <= {shreg[6:0], sda_bit};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            if (shreg[6:0] == DEV_ADDR) begin
                                rw    <= sda_bit;
                                state <= DEV_ACK;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    WADDR, WDATA: begin
                        shreg  <= {shreg[6:0], sda_bit};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= (state == WADDR) ? WADDR_ACK : WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        shreg  <= {shreg[6:0], 1'b0};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= RD_MACK;
                            ptr   <= ptr + 8'd1;
                        end
                    end
                    RD_MACK: begin
                        if (!sda_bit) begin
                            shreg <= rd_byte;
                            state <= RDATA;
                        end else begin
                            state  <= WAIT_STOP;
                            active <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                unique case (state)
                    DEV_ACK: begin
                        if (!drive) begin
                            drive  <= 1'b1;
                            active <= 1'b1;
                        end else if (rw) begin
                            state <= RDATA;
                            shreg <= rd_byte;
                            drive <= ~rd_byte[7];
                        end else begin
                            state <= WADDR;
                            drive <= 1'b0;
                        end
                    end
                    WADDR_ACK: begin
                        if (!drive) begin
                            drive <= 1'b1;
                        end else begin
                            ptr   <= shreg;
                            state <= WDATA;
                            drive <= 1'b0;
                        end
                    end
                    WDATA_ACK: begin
                        if (!drive) begin
                            drive <= 1'b1;
                        end else begin
                            ptr   <= ptr_page_inc;
                            state <= WDATA;
                            drive <= 1'b0;
                        end
                    end
                    RDATA:   drive <= ~shreg[7];
                    RD_MACK: drive <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

I2C responder that models a 256-byte serial EEPROM (24C02-style) on the board-level I2C bus. It answers the team's I2C controller that the CPU drives for EEPROM demo traffic. It supports byte write, page write, current-address read, random read and sequential read. The block oversamples SCL/SDA on the system clock and drives SDA open-drain through an output-enable.

## Interface
- DEV_ADDR, 7'b1010000, 7-bit device address that the block answers to.
- PAGE_BYTES, 8, page-write wrap size; power of two, 2..256.
- clk  input  1  system clock; sole clock.
- clrn  input  1  asynchronous active-low reset.
- scl  input  1  I2C clock from the bus; asynchronous to clk.
- sda_in  input  1  I2C data as seen on the bus; asynchronous to clk.
- sda_oe  output  1  1 = pull SDA low, 0 = release. The pad ties the line low when this is 1.
- active  output  1  1 while addressed, from the ACK of a matching device address until STOP, repeated START or NACK-terminated read.

## Operation
- Input conditioning:
  - scl and sda_in each pass through a 2-flop synchronizer, then a 1-flop history register for edge detection.
- Bus events, evaluated on the synchronized signals:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Bit sample: SCL rising edge, MSB first.
  - sda_oe may change only on a detected SCL falling edge, except for the release on STOP/START.
- States:
  - IDLE
  - DEV (shift 8 bits)
  - DEV_ACK
  - WADDR (shift 8)
  - WADDR_ACK
  - WDATA (shift 8)
  - WDATA_ACK
  - RDATA (drive 8)
  - RD_MACK (sample master ACK)
  - WAIT_STOP
- Transitions:
  - IDLE -> DEV on START.
  - DEV:
    - Address match: R/W=0 -> ACK -> WADDR; R/W=1 -> ACK -> RDATA, loading the byte at the pointer.
    - Mismatch: no ACK (sda_oe stays 0) -> IDLE.
  - WADDR_ACK loads pointer <= received byte, then -> WDATA.
  - WDATA_ACK:
    - Writes mem[pointer] <= byte at the ACK.
    - Pointer low log2(PAGE_BYTES) bits increment modulo PAGE_BYTES; the upper bits are unchanged.
    - Then -> WDATA.
  - RDATA: after 8 bits, release SDA -> RD_MACK.
    - Master ACK (SDA low): pointer <= pointer+1 modulo 256, load the next byte, -> RDATA.
    - Master NACK: -> WAIT_STOP.
  - START in any state -> DEV (repeated START); the pointer is preserved. This is how random read works.
  - STOP in any state -> IDLE, sda_oe <= 0.
- Current-address read:
  - After a write, the pointer is the post-increment value.
  - After a read, the pointer is the address following the last byte transferred.
- Memory:
  - 256x8 register array, not reset.
  - Contents are undefined until written.
  - No write-cycle busy period: the array is immediately readable.
- ACK drive:
  - sda_oe=1 from the SCL fall after bit 8 until the next SCL fall.
  - During RDATA, sda_oe = ~bit for each bit.

## Timing
- Reset (clrn=0, asynchronous):
  - sda_oe=0, active=0, state IDLE, pointer 0, bit counter 0, synchronizers loaded with 1.
- Reset mid-transfer releases SDA immediately. After clrn rises, the block ignores the bus until the next START.
- Detection latency:
  - A bus event is acted on 3 clk after the pin change (2 sync + 1 edge).
  - sda_oe updates on the 4th clk edge after the SCL fall pin change.
- Bus requirement: SCL high and low phases are each ≥ 6 clk. SDA setup/hold relative to SCL is ≥ 2 clk.
- Simultaneous events:
  - A START/STOP and a SCL edge cannot coincide by bus protocol.
  - If SDA and SCL change in the same clk, the SCL edge takes priority and SDA is treated as data.
- Bit counting:
  - The bit counter is 3 bits and wraps 7->0 on the 8th sample.
  - An ACK slot is exactly one SCL period.
- active:
  - Rises with the DEV_ACK drive.
  - Falls on STOP, START, or entry to WAIT_STOP.

## Test plan
- Byte write then random read:
  - Stimulus: START, A0, 10, 5A, STOP; START, A0, 10, START, A1, read 1 byte, NACK, STOP.
  - Response: three slave ACKs on the write, ACKs on A0/10/A1, read byte 0x5A.
- Page write wrap, PAGE_BYTES=8:
  - Stimulus: write 9 bytes 01..09 starting at 0x06.
  - Response: mem[06]=01, mem[07]=02, mem[00]=03 … mem[05]=08, mem[06]=09.
- Sequential read wrap:
  - Stimulus: preload mem[FE]=AA and mem[FF]=BB (via writes), random read from FE with master ACK twice, then NACK.
  - Response: AA, BB, then mem[00]; after STOP, a current-address read returns mem[01].
- Address mismatch:
  - Stimulus: START, A2, three data bytes.
  - Response: sda_oe never asserts, active stays 0, memory unchanged.
- Reset mid-read:
  - Stimulus: assert clrn low while the slave drives a 0 bit.
  - Response: sda_oe=0 within the same cycle, no response until the next START.
  - Then: a following current-address read returns mem[00], since the pointer was reset.
- STOP mid-byte:
  - Stimulus: write A0, 20, then 4 bits of data, then STOP.
  - Response: no write occurs, state IDLE, active=0.
